// File: rtl/pc_stack_unit.sv
// Program-counter unit with an integrated return-address stack for the fetch stage.
// Optional feature macro PC_ABS_JUMP_EN adds the abs input to make jump/call targets absolute.
module pc_stack_unit #(
  parameter int                ADDR_W      = 12,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
`ifdef PC_ABS_JUMP_EN
  input  logic                               abs,
`endif
  input  logic [ADDR_W-1:0]                  offset,
  output logic [ADDR_W-1:0]                  pc,
  output logic [ADDR_W-1:0]                  stk_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty,
  output logic                               ovf,
  output logic                               unf
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_nxt;
  logic [DW-1:0]     depth_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              push;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     top_idx;

  assign pc_inc  = pc + ADDR_W'(1);
  assign full    = (depth == DW'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign wr_idx  = IW'(depth);
  assign top_idx = IW'(depth - DW'(1));
  assign stk_top = empty ? '0 : stack[top_idx];

`ifdef PC_ABS_JUMP_EN
  assign target = abs ? offset : pc + offset;
`else
  assign target = pc + offset;
`endif

  // Priority ret > call > jump > increment; stall and reset are applied in the register.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    pc_nxt    = pc_inc;
    depth_nxt = depth;
    ovf_nxt   = ovf;
    unf_nxt   = unf;
    push      = 1'b0;
    if (ret) begin
      if (!empty) begin
        pc_nxt    = stk_top;
        depth_nxt = depth - DW'(1);
      end else begin
        unf_nxt = 1'b1;
      end
    end else if (call) begin
      pc_nxt = target;
      if (!full) begin
        push      = 1'b1;
        depth_nxt = depth + DW'(1);
      end else begin
        ovf_nxt = 1'b1;
      end
    end else if (jump) begin
      pc_nxt = target;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_ADDR;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (!stall) begin
      pc    <= pc_nxt;
      depth <= depth_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

  // NOTE: stack storage is not reset; entries above depth are never observed.
  always_ff @(posedge clk) begin
    if (!rst && !stall && push) begin
      stack[wr_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomised and directed bench for pc_stack_unit against a queue-based reference model.
// Define PC_ABS_JUMP_EN for both files to exercise the absolute-target feature.
module tb_pc_stack_unit;

  localparam int ADDR_W      = 12;
  localparam int STACK_DEPTH = 8;
  localparam int RESET_ADDR  = 0;
  localparam int MASK        = (1 << ADDR_W) - 1;
  localparam int DW          = $clog2(STACK_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, stall, jump, call, ret;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] pc, stk_top;
  logic [DW-1:0]     depth;
  logic              full, empty, ovf, unf;
  bit                abs_r;
`ifdef PC_ABS_JUMP_EN
  logic              abs;
  assign abs = abs_r;
`endif

  pc_stack_unit #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .RESET_ADDR  (ADDR_W'(RESET_ADDR))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .jump    (jump),
    .call    (call),
    .ret     (ret),
`ifdef PC_ABS_JUMP_EN
    .abs     (abs),
`endif
    .offset  (offset),
    .pc      (pc),
    .stk_top (stk_top),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural pc plus a LIFO queue of return addresses.
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(bit r, bit s, bit j, bit c, bit rt, bit a, int off);
    int tgt;
    tgt = a ? off : (m_pc + off) & MASK;
    if (r) begin
      m_pc = RESET_ADDR;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (s) begin
      // hold everything
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
        m_pc  = (m_pc + 1) & MASK;
        m_unf = 1;
      end
    end else if (c) begin
      if (m_stk.size() < STACK_DEPTH) m_stk.push_back((m_pc + 1) & MASK);
      else m_ovf = 1;
      m_pc = tgt;
    end else if (j) begin
      m_pc = tgt;
    end else begin
      m_pc = (m_pc + 1) & MASK;
    end
  endfunction

  task automatic compare_all(string ph);
    int d;
    d = m_stk.size();
    check({ph, ".pc"},      int'(pc),      m_pc);
    check({ph, ".depth"},   int'(depth),   d);
    check({ph, ".stk_top"}, int'(stk_top), (d > 0) ? m_stk[d-1] : 0);
    check({ph, ".full"},    int'(full),    int'(d == STACK_DEPTH));
    check({ph, ".empty"},   int'(empty),   int'(d == 0));
    check({ph, ".ovf"},     int'(ovf),     int'(m_ovf));
    check({ph, ".unf"},     int'(unf),     int'(m_unf));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic cyc(string ph, bit r, bit s, bit j, bit c, bit rt, bit a, int off);
    rst = r; stall = s; jump = j; call = c; ret = rt; abs_r = a;
    offset = ADDR_W'(off);
    @(posedge clk);
    model_step(r, s, j, c, rt, a, off & MASK);
    #1;
    compare_all(ph);
  endtask

  task automatic idle(string ph);
    cyc(ph, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    abs_r = 1'b0; offset = '0;
    m_pc = 0; m_ovf = 0; m_unf = 0;

    // Reset and idle increment, then reset while stalled.
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    check("reset.pc_const", int'(pc), 0);
    for (int i = 1; i <= 4; i++) begin
      idle("idle");
      check("idle.pc_const", int'(pc), i);
    end
    cyc("rst_stall", 1, 1, 0, 0, 0, 0, 0);
    check("rst_stall.pc_const", int'(pc), 0);

    // Call followed by return.
    cyc("goto10", 0, 0, 1, 0, 0, 0, 'h010);
    cyc("call", 0, 0, 0, 1, 0, 0, 'h020);
    check("call.pc_const", int'(pc), 'h030);
    check("call.top_const", int'(stk_top), 'h011);
    cyc("ret", 0, 0, 0, 0, 1, 0, 0);
    check("ret.pc_const", int'(pc), 'h011);

    // Wrap-around in both directions.
    cyc("goto_ffe", 0, 0, 1, 0, 0, 0, ('hFFE - m_pc) & MASK);
    cyc("wrap_fwd", 0, 0, 1, 0, 0, 0, 'h003);
    check("wrap_fwd.pc_const", int'(pc), 'h001);
    cyc("goto5", 0, 0, 1, 0, 0, 0, 'h004);
    cyc("wrap_neg", 0, 0, 1, 0, 0, 0, 'hFFD);
    check("wrap_neg.pc_const", int'(pc), 'h002);

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 9; i++) begin
      cyc("fill", 0, 0, 0, 1, 0, 0, 1);
      if (i == 8) check("fill8.full", int'(full), 1);
    end
    check("fill9.ovf", int'(ovf), 1);
    check("fill9.depth", int'(depth), 8);
    for (int i = 0; i < 8; i++) cyc("drain", 0, 0, 0, 0, 1, 0, 0);
    check("drain.empty", int'(empty), 1);
    cyc("underflow", 0, 0, 0, 0, 1, 0, 0);
    check("underflow.unf", int'(unf), 1);

    // Simultaneous requests and stall.
    cyc("prio_rst", 1, 0, 0, 0, 0, 0, 0);
    cyc("prio_call", 0, 0, 0, 1, 0, 0, 'h100);
    cyc("prio_all", 0, 0, 1, 1, 1, 0, 'h055);
    check("prio_all.pc_const", int'(pc), 'h001);
    cyc("prio_call2", 0, 0, 0, 1, 0, 0, 'h040);
    cyc("stall_ret", 0, 1, 0, 0, 1, 0, 0);
    check("stall_ret.pc_const", int'(pc), 'h041);
    cyc("unstall_ret", 0, 0, 0, 0, 1, 0, 0);
    check("unstall_ret.pc_const", int'(pc), 'h002);

`ifdef PC_ABS_JUMP_EN
    cyc("goto100", 0, 0, 1, 0, 0, 0, ('h100 - m_pc) & MASK);
    cyc("abs_call", 0, 0, 0, 1, 0, 1, 'h040);
    check("abs_call.pc_const", int'(pc), 'h040);
    check("abs_call.top_const", int'(stk_top), 'h101);
    cyc("rel_jump", 0, 0, 1, 0, 0, 0, 2);
    check("rel_jump.pc_const", int'(pc), 'h042);
`endif

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, j, c, rt, a;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 4) == 0);
      rt = ($urandom_range(0, 9) < 4);
      c  = ($urandom_range(0, 9) < 5);
      j  = $urandom_range(0, 1);
`ifdef PC_ABS_JUMP_EN
      a  = $urandom_range(0, 1);
`else
      a  = 1'b0;
`endif
      cyc("rand", r, s, j, c, rt, a, int'($urandom_range(0, MASK)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
